// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS down-counting timers (one-shot or periodic) with
// sticky pending bits, per-channel interrupt enables, a prioritised interrupt
// request and a free-running 64-bit stable counter, all behind a CSR port.
module csr_timer_bank #(
  parameter int unsigned        NUM_TIMERS = 4,
  parameter int unsigned        CNT_W      = 32,
  parameter int unsigned        ADDR_W     = 14,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 14'h041,
  parameter logic [ADDR_W-1:0]  IE_ADDR    = 14'h040
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_we,
  input  logic [ADDR_W-1:0]     csr_wnum,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wdata,
  input  logic [ADDR_W-1:0]     csr_rnum,
  output logic [31:0]           csr_rdata,
  output logic                  csr_hit,
  output logic [NUM_TIMERS-1:0] timer_pending,
  output logic                  timer_irq,
  output logic [2:0]            timer_irq_id,
  output logic [63:0]           stable_cnt
);

  // Register slot inside a channel's 4-CSR window.
  typedef enum logic [1:0] {
    REG_TCFG  = 2'd0,
    REG_TVAL  = 2'd1,
    REG_TICLR = 2'd2,
    REG_TSTAT = 2'd3
  } reg_e;

  typedef struct packed {
    logic             en;
    logic             periodic;
    logic [CNT_W-3:0] initval;
    logic [CNT_W-1:0] cnt;
    logic             pending;
  } chan_t;

  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * NUM_TIMERS);

  chan_t                 chan_q [NUM_TIMERS];
  chan_t                 chan_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] ie_q, ie_d;
  logic [63:0]           stable_q, stable_d;

  logic [ADDR_W-1:0]     w_off, r_off;
  logic                  w_chan_hit, r_chan_hit;
  reg_e                  w_reg, r_reg;
  logic [NUM_TIMERS-1:0] irq_active;

  // Decode write and read CSR numbers into channel window offsets.
  always_comb begin
    w_off      = csr_wnum - BASE_ADDR;
    r_off      = csr_rnum - BASE_ADDR;
    w_chan_hit = (csr_wnum >= BASE_ADDR) && (w_off < SPAN);
    r_chan_hit = (csr_rnum >= BASE_ADDR) && (r_off < SPAN);
    w_reg      = reg_e'(w_off[1:0]);
    r_reg      = reg_e'(r_off[1:0]);
  end

  // Next state: masked CSR writes, counting/reload, sticky expiry, IE, stable counter.
  always_comb begin
    logic             sel;
    logic             cfg_wr;
    logic             clr_wr;
    logic [CNT_W-1:0] cfg_old;
    logic [CNT_W-1:0] cfg_new;
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    sel      = 1'b0;
    cfg_wr   = 1'b0;
    clr_wr   = 1'b0;
    cfg_old  = '0;
    cfg_new  = '0;
    ie_d     = ie_q;
    stable_d = stable_q + 64'd1;
    for (int i = 0; i < int'(NUM_TIMERS); i++) begin
      chan_d[i] = chan_q[i];
      sel     = csr_we && w_chan_hit && (w_off[ADDR_W-1:2] == (ADDR_W-2)'(i));
      cfg_wr  = sel && (w_reg == REG_TCFG);
      clr_wr  = sel && (w_reg == REG_TICLR) && csr_wmask[0] && csr_wdata[0];
      cfg_old = {chan_q[i].initval, chan_q[i].periodic, chan_q[i].en};
      cfg_new = (csr_wmask[CNT_W-1:0] & csr_wdata[CNT_W-1:0]) |
                (~csr_wmask[CNT_W-1:0] & cfg_old);

      if (cfg_wr) begin
        chan_d[i].en       = cfg_new[0];
        chan_d[i].periodic = cfg_new[1];
        chan_d[i].initval  = cfg_new[CNT_W-1:2];
        // Enabling always restarts from the (possibly new) initial value;
        // disabling leaves the count frozen where it is.
        if (cfg_new[0]) begin
          chan_d[i].cnt = {cfg_new[CNT_W-1:2], 2'b00};
        end
      end else if (chan_q[i].en && (chan_q[i].cnt != '1)) begin
        if ((chan_q[i].cnt == '0) && chan_q[i].periodic) begin
          chan_d[i].cnt = {chan_q[i].initval, 2'b00};
        end else begin
          chan_d[i].cnt = chan_q[i].cnt - CNT_W'(1);
        end
      end

      // Expiry takes priority over a software clear in the same cycle.
      if (chan_q[i].en && (chan_q[i].cnt == '0)) begin
        chan_d[i].pending = 1'b1;
      end else if (clr_wr) begin
        chan_d[i].pending = 1'b0;
      end
    end

    if (csr_we && (csr_wnum == IE_ADDR)) begin
      ie_d = (csr_wmask[NUM_TIMERS-1:0] & csr_wdata[NUM_TIMERS-1:0]) |
             (~csr_wmask[NUM_TIMERS-1:0] & ie_q);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      // NOTE: the channel array is a handful of control flops, not a RAM, so every entry is reset.
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
        chan_q[i] <= '{en: 1'b0, periodic: 1'b0, initval: '0, cnt: '1, pending: 1'b0};
      end
      ie_q     <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
        chan_q[i] <= chan_d[i];
      end
      ie_q     <= ie_d;
      stable_q <= stable_d;
    end
  end

  // Combinational CSR read mux; unmapped numbers read 0 with csr_hit low.
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    if (csr_rnum == IE_ADDR) begin
      csr_hit   = 1'b1;
      csr_rdata = 32'(ie_q);
    end else if (r_chan_hit) begin
      csr_hit = 1'b1;
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
        if (r_off[ADDR_W-1:2] == (ADDR_W-2)'(i)) begin
          case (r_reg)
            REG_TCFG:  csr_rdata = 32'({chan_q[i].initval, chan_q[i].periodic, chan_q[i].en});
            REG_TVAL:  csr_rdata = 32'(chan_q[i].cnt);
            REG_TICLR: csr_rdata = '0;
            REG_TSTAT: csr_rdata = {29'd0, (chan_q[i].cnt == '1), chan_q[i].en, chan_q[i].pending};
            default:   csr_rdata = '0;
          endcase
        end
      end
    end
  end

  // Gather pending bits into the output vector.
  always_comb begin
    timer_pending = '0;
    for (int i = 0; i < int'(NUM_TIMERS); i++) begin
      timer_pending[i] = chan_q[i].pending;
    end
  end

  // Interrupt request and lowest-index priority encode.
  always_comb begin
    irq_active   = timer_pending & ie_q;
    timer_irq    = |irq_active;
    timer_irq_id = 3'd0;
    for (int i = int'(NUM_TIMERS) - 1; i >= 0; i--) begin
      if (irq_active[i]) begin
        timer_irq_id = 3'(i);
      end
    end
  end

  assign stable_cnt = stable_q;

endmodule

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
- Parametrised multi-channel timer and interrupt block; successor to the single-timer logic inside the CSR file.
- Provides NUM_TIMERS independent down-counters with one-shot or periodic mode, per-channel sticky pending bits and per-channel interrupt enables.
- Produces a prioritised timer interrupt request and a free-running 64-bit stable counter.
- Sits beside the CSR file and is accessed through the same CSR read/write port from the WB stage.

Parameters:
- NUM_TIMERS, 4, number of timer channels (1..8).
- CNT_W, 32, counter width; INITVAL field is CNT_W-2 bits.
- ADDR_W, 14, CSR number width.
- BASE_ADDR, 14'h041, CSR number of channel 0 TCFG. Channel n uses BASE_ADDR+4n+{0:TCFG, 1:TVAL, 2:TICLR, 3:TSTAT}.
- IE_ADDR, 14'h040, CSR number of the channel interrupt-enable register; bits [NUM_TIMERS-1:0] are valid.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, synchronous active-low reset.
- csr_we, input, 1, write strobe.
- csr_wnum, input, ADDR_W, write CSR number.
- csr_wmask, input, 32, bit write mask.
- csr_wdata, input, 32, write data.
- csr_rnum, input, ADDR_W, read CSR number.
- csr_rdata, output, 32, combinational read data; 0 for unmapped numbers.
- csr_hit, output, 1, csr_rnum maps to this block.
- timer_pending, output, NUM_TIMERS, sticky expiry bits.
- timer_irq, output, 1, |(timer_pending & ie).
- timer_irq_id, output, 3, lowest-index channel with (pending & ie); 0 when timer_irq=0.
- stable_cnt, output, 64, free-running counter.

Behaviour:
- Reset (resetn=0 at a clk edge) forces:
  - all en, periodic, initval, pending and ie bits to 0;
  - every counter to all-ones;
  - stable_cnt to 0.
  - Outputs therefore read 0, except TVAL, which reads all-ones.
- Reset mid-count aborts the count immediately; no pending bit is set on the cycle reset is applied.
- Masked write: new = (wmask & wdata) | (~wmask & old). Each write takes effect on the next edge.
- TCFG layout: bit0 En, bit1 Periodic, bits[CNT_W-1:2] InitVal.
- TCFG write with the resulting En=1: counter <= {InitVal_new, 2'b00} on the next edge, regardless of its current value.
- TCFG write with En=0: counter freezes at its current value.
- Counting: each cycle with En=1 and counter != all-ones:
  - if counter == 0 and Periodic=1, reload {InitVal, 2'b00};
  - otherwise counter <= counter - 1.
  - A one-shot channel therefore ends at all-ones and stops.
  - Periodic period = InitVal*4 + 1 cycles.
- Expiry: when En=1 and counter == 0, pending[n] <= 1 on the next edge. Pending stays set until cleared.
- TICLR: write with wmask[0] & wdata[0] = 1 clears pending[n]. Reads as 0.
- Simultaneous TICLR clear and expiry on the same cycle: set wins, pending stays 1.
- InitVal=0 with Periodic=1: counter holds 0 and pending re-asserts every cycle.
- TVAL is read-only (writes ignored) and returns the counter zero-extended to 32 bits.
- TSTAT is read-only: bit0 pending, bit1 En, bit2 (counter == all-ones).
- IE register: read/write, bits above NUM_TIMERS-1 read 0.
- Interrupt outputs are combinational from registered state, so there is no added latency after a pending or ie change.
- stable_cnt increments by 1 every cycle and wraps from 2^64-1 to 0.
- Several channels written in one cycle is impossible: one write port, one channel per write.

Test Plan:
- Reset: hold resetn=0 for 2 cycles, then release -> all outputs 0, TVAL ch0 reads 32'hFFFF_FFFF, stable_cnt=1 on the first cycle after release.
- One-shot: write ch0 TCFG=32'h0000_0009 (InitVal=2, En=1) -> TVAL reads 8 next cycle, pending[0]=1 nine cycles after the counter reaches 8, counter then reads all-ones and holds; TICLR write 1 -> pending[0]=0.
- Periodic with priority: ch1 TCFG=32'h0000_0007 (InitVal=1, Periodic, En), ch3 TCFG=32'h0000_000F, IE=4'b1010 -> ch1 pending every 5 cycles, timer_irq_id=1 while both ch1 and ch3 are pending, =3 after clearing ch1 only.
- Clear/expiry collision: issue TICLR on ch1 in the exact cycle its counter is 0 -> pending[1] remains 1.
- Masked write and freeze: mid-count write TCFG with wmask=1, wdata=0 -> En=0, TVAL frozen; Periodic/InitVal unchanged on TCFG readback; writing wmask=1, wdata=1 reloads from InitVal.
- Reset mid-count and unmapped read: assert resetn=0 while ch0 counter=1 -> no pending; read csr_rnum=14'h000 -> csr_hit=0, csr_rdata=0.
